// File: rtl/control.sv
// ----------------------------------------------------------------------------
// control -- instruction decoder for the single-issue datapath, plus two
//            small operand/destination selectors used alongside it.
//
// control ports
//   clk          system clock (only the halt flag is clocked)
//   rst          asynchronous, active-low reset
//   op           instruction[31:26]
//   funct        instruction[5:0]
//   harzard      stall request; the current instruction becomes a bubble
//   reg_rs_d     register-file rs value, for branch compare
//   reg_rt_d     register-file rt value, for branch compare
//   is_immd      ALU operand 2 = sign-extended immediate, destination = rt
//   only_shamt   ALU operand 1 = zero-extended shamt
//   mem_w/mem_r  data-memory write / read enable
//   alu_op       ALU operation code
//   wb_en        register write-back enable
//   branch_taken redirect PC by branch offset
//   jump_taken   redirect PC to jump target
//   terminate    halt indication (decoded halt OR sticky halt flag)
//
// data_mux ports : sel, in1 (WORD), in2 (WORD), out (WORD); out = sel ? in2 : in1
// reg_mux  ports : sel, in1 (5),    in2 (5),    out (5);    out = sel ? in2 : in1
// ----------------------------------------------------------------------------
`ifndef WORD
`define WORD 32
`endif

module data_mux (
   input  logic              sel,
   input  logic [`WORD-1:0]  in1,
   input  logic [`WORD-1:0]  in2,
   output logic [`WORD-1:0]  out
);
   assign out = sel ? in2 : in1;
endmodule

module reg_mux (
   input  logic        sel,
   input  logic [4:0]  in1,
   input  logic [4:0]  in2,
   output logic [4:0]  out
);
   assign out = sel ? in2 : in1;
endmodule

module control (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic              harzard,
   input  logic [`WORD-1:0]  reg_rs_d,
   input  logic [`WORD-1:0]  reg_rt_d,
   output logic              is_immd,
   output logic              only_shamt,
   output logic              mem_w,
   output logic              mem_r,
   output logic [3:0]        alu_op,
   output logic              wb_en,
   output logic              branch_taken,
   output logic              jump_taken,
   output logic              terminate
);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_NOR = 4'd5;
   localparam logic [3:0] ALU_SLT = 4'd6;
   localparam logic [3:0] ALU_SLL = 4'd7;
   localparam logic [3:0] ALU_SRL = 4'd8;
   localparam logic [3:0] ALU_SRA = 4'd9;

   logic       dec_mem_w, dec_mem_r, dec_wb_en;
   logic       dec_branch, dec_jump, dec_term;
   logic       halt_q;
   logic       en_ok;

   always_comb begin
      is_immd    = 1'b0;
      only_shamt = 1'b0;
      alu_op     = ALU_ADD;
      dec_mem_w  = 1'b0;
      dec_mem_r  = 1'b0;
      dec_wb_en  = 1'b0;
      dec_branch = 1'b0;
      dec_jump   = 1'b0;
      dec_term   = 1'b0;
      case (op)
         6'h00: begin
            // Unknown funct leaves the NOP defaults in place (wb_en stays 0).
            dec_wb_en = 1'b1;
            case (funct)
               6'h20, 6'h21: alu_op = ALU_ADD;
               6'h22, 6'h23: alu_op = ALU_SUB;
               6'h24:        alu_op = ALU_AND;
               6'h25:        alu_op = ALU_OR;
               6'h26:        alu_op = ALU_XOR;
               6'h27:        alu_op = ALU_NOR;
               6'h2A:        alu_op = ALU_SLT;
               6'h00: begin alu_op = ALU_SLL; only_shamt = 1'b1; end
               6'h02: begin alu_op = ALU_SRL; only_shamt = 1'b1; end
               6'h03: begin alu_op = ALU_SRA; only_shamt = 1'b1; end
               6'h04:        alu_op = ALU_SLL;
               6'h06:        alu_op = ALU_SRL;
               6'h07:        alu_op = ALU_SRA;
               default:      dec_wb_en = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin is_immd = 1'b1; dec_wb_en = 1'b1; alu_op = ALU_ADD; end
         6'h0C:        begin is_immd = 1'b1; dec_wb_en = 1'b1; alu_op = ALU_AND; end
         6'h0D:        begin is_immd = 1'b1; dec_wb_en = 1'b1; alu_op = ALU_OR;  end
         6'h0E:        begin is_immd = 1'b1; dec_wb_en = 1'b1; alu_op = ALU_XOR; end
         6'h0A:        begin is_immd = 1'b1; dec_wb_en = 1'b1; alu_op = ALU_SLT; end
         6'h23:        begin is_immd = 1'b1; dec_mem_r = 1'b1; dec_wb_en = 1'b1; end
         6'h2B:        begin is_immd = 1'b1; dec_mem_w = 1'b1; end
         6'h04: begin
            alu_op     = ALU_SUB;
            dec_branch = (reg_rs_d == reg_rt_d);
         end
         6'h05: begin
            alu_op     = ALU_SUB;
            dec_branch = (reg_rs_d != reg_rt_d);
         end
         6'h02:        dec_jump = 1'b1;
         6'h3F:        dec_term = 1'b1;
         default: ;
      endcase
   end

   // Sticky halt: only a non-stalled halt instruction may set it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         halt_q <= 1'b0;
      else if (dec_term && !harzard)
         halt_q <= 1'b1;
   end

   // Side-effecting enables are suppressed in reset, on a stall, and once halted.
   assign en_ok        = rst & ~harzard & ~halt_q;
   assign mem_w        = dec_mem_w  & en_ok;
   assign mem_r        = dec_mem_r  & en_ok;
   assign wb_en        = dec_wb_en  & en_ok;
   assign branch_taken = dec_branch & en_ok;
   assign jump_taken   = dec_jump   & en_ok;
   assign terminate    = rst & ((dec_term & ~harzard) | halt_q);

endmodule

// File: tb/tb_control.sv
`timescale 1ns/1ps
module tb_control;
   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op, funct;
   logic        harzard;
   logic [31:0] reg_rs_d, reg_rt_d;
   logic        is_immd, only_shamt, mem_w, mem_r, wb_en;
   logic        branch_taken, jump_taken, terminate;
   logic [3:0]  alu_op;

   logic        dm_sel, rm_sel;
   logic [31:0] dm_in1, dm_in2, dm_out;
   logic [4:0]  rm_in1, rm_in2, rm_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   control dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .harzard(harzard),
      .reg_rs_d(reg_rs_d), .reg_rt_d(reg_rt_d),
      .is_immd(is_immd), .only_shamt(only_shamt), .mem_w(mem_w), .mem_r(mem_r),
      .alu_op(alu_op), .wb_en(wb_en), .branch_taken(branch_taken),
      .jump_taken(jump_taken), .terminate(terminate)
   );

   data_mux u_dm (.sel(dm_sel), .in1(dm_in1), .in2(dm_in2), .out(dm_out));
   reg_mux  u_rm (.sel(rm_sel), .in1(rm_in1), .in2(rm_in2), .out(rm_out));

   task automatic test_reset();
      rst = 1'b0; harzard = 1'b0; op = 6'h00; funct = 6'h20;
      reg_rs_d = '0; reg_rt_d = '0;
      #1;
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rst_wb_en got %0b exp 0", wb_en); end
      checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL rst_alu_op got %0d exp 0", alu_op); end
      op = 6'h3F; #1;
      checks++; if (terminate !== 1'b0) begin errors++; $display("FAIL rst_terminate got %0b exp 0", terminate); end
      op = 6'h23; #1;
      checks++; if (mem_r !== 1'b0) begin errors++; $display("FAIL rst_mem_r got %0b exp 0", mem_r); end
      checks++; if (is_immd !== 1'b1) begin errors++; $display("FAIL rst_is_immd got %0b exp 1", is_immd); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_add();
      op = 6'h00; funct = 6'h20; harzard = 1'b0; #1;
      checks++; if (alu_op !== 4'd0) begin errors++; $display("FAIL add_alu_op got %0d exp 0", alu_op); end
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL add_wb_en got %0b exp 1", wb_en); end
      checks++; if (is_immd !== 1'b0 || only_shamt !== 1'b0) begin errors++; $display("FAIL add_sel got %0b%0b exp 00", is_immd, only_shamt); end
      checks++; if (mem_r !== 1'b0 || mem_w !== 1'b0) begin errors++; $display("FAIL add_mem got %0b%0b exp 00", mem_r, mem_w); end
      funct = 6'h23; #1;
      checks++; if (alu_op !== 4'd1) begin errors++; $display("FAIL subu_alu_op got %0d exp 1", alu_op); end
      funct = 6'h27; #1;
      checks++; if (alu_op !== 4'd5) begin errors++; $display("FAIL nor_alu_op got %0d exp 5", alu_op); end
      funct = 6'h2A; #1;
      checks++; if (alu_op !== 4'd6) begin errors++; $display("FAIL slt_alu_op got %0d exp 6", alu_op); end
      funct = 6'h07; #1;
      checks++; if (alu_op !== 4'd9 || only_shamt !== 1'b0) begin errors++; $display("FAIL srav got %0d/%0b exp 9/0", alu_op, only_shamt); end
   endtask

   task automatic test_sll();
      op = 6'h00; funct = 6'h00; #1;
      checks++; if (only_shamt !== 1'b1) begin errors++; $display("FAIL sll_only_shamt got %0b exp 1", only_shamt); end
      checks++; if (alu_op !== 4'd7) begin errors++; $display("FAIL sll_alu_op got %0d exp 7", alu_op); end
      funct = 6'h03; #1;
      checks++; if (alu_op !== 4'd8 + 4'd1 || only_shamt !== 1'b1) begin errors++; $display("FAIL sra got %0d/%0b exp 9/1", alu_op, only_shamt); end
      dm_sel = 1'b1; dm_in1 = 32'hDEAD_BEEF; dm_in2 = 32'd5; #1;
      checks++; if (dm_out !== 32'd5) begin errors++; $display("FAIL dmux_sel1 got %0h exp 5", dm_out); end
      dm_sel = 1'b0; #1;
      checks++; if (dm_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dmux_sel0 got %0h exp deadbeef", dm_out); end
   endtask

   task automatic test_itype();
      op = 6'h0D; #1;
      checks++; if (alu_op !== 4'd3 || is_immd !== 1'b1 || wb_en !== 1'b1) begin errors++; $display("FAIL ori got %0d/%0b/%0b exp 3/1/1", alu_op, is_immd, wb_en); end
      op = 6'h0A; #1;
      checks++; if (alu_op !== 4'd6 || is_immd !== 1'b1) begin errors++; $display("FAIL slti got %0d/%0b exp 6/1", alu_op, is_immd); end
      op = 6'h02; #1;
      checks++; if (jump_taken !== 1'b1 || wb_en !== 1'b0) begin errors++; $display("FAIL j got %0b/%0b exp 1/0", jump_taken, wb_en); end
      op = 6'h11; #1;
      checks++; if ({wb_en, mem_r, mem_w, jump_taken, branch_taken, is_immd, alu_op} !== 10'b0) begin errors++; $display("FAIL nop_op got %0b/%0d exp 0/0", wb_en, alu_op); end
      op = 6'h00; funct = 6'h3E; #1;
      checks++; if (wb_en !== 1'b0 || alu_op !== 4'd0) begin errors++; $display("FAIL nop_funct got %0b/%0d exp 0/0", wb_en, alu_op); end
   endtask

   task automatic test_lw_sw();
      op = 6'h23; #1;
      checks++; if (is_immd !== 1'b1 || mem_r !== 1'b1 || wb_en !== 1'b1) begin errors++; $display("FAIL lw got %0b%0b%0b exp 111", is_immd, mem_r, wb_en); end
      checks++; if (alu_op !== 4'd0 || mem_w !== 1'b0) begin errors++; $display("FAIL lw_alu got %0d/%0b exp 0/0", alu_op, mem_w); end
      op = 6'h2B; #1;
      checks++; if (mem_w !== 1'b1 || wb_en !== 1'b0 || mem_r !== 1'b0) begin errors++; $display("FAIL sw got %0b%0b%0b exp 100", mem_w, wb_en, mem_r); end
      rm_sel = 1'b1; rm_in1 = 5'd17; rm_in2 = 5'd0; #1;
      checks++; if (rm_out !== 5'd0) begin errors++; $display("FAIL rmux_sel1 got %0d exp 0", rm_out); end
      rm_sel = 1'b0; #1;
      checks++; if (rm_out !== 5'd17) begin errors++; $display("FAIL rmux_sel0 got %0d exp 17", rm_out); end
   endtask

   task automatic test_branch();
      reg_rs_d = 32'h1234; reg_rt_d = 32'h1234; op = 6'h04; #1;
      checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL beq_eq got %0b exp 1", branch_taken); end
      checks++; if (alu_op !== 4'd1 || wb_en !== 1'b0 || is_immd !== 1'b0) begin errors++; $display("FAIL beq_ctl got %0d/%0b/%0b exp 1/0/0", alu_op, wb_en, is_immd); end
      op = 6'h05; #1;
      checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bne_eq got %0b exp 0", branch_taken); end
      reg_rt_d = 32'h1235; op = 6'h04; #1;
      checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL beq_ne got %0b exp 0", branch_taken); end
      op = 6'h05; #1;
      checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL bne_ne got %0b exp 1", branch_taken); end
      reg_rt_d = 32'h8000_1234; op = 6'h04; #1;
      checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL beq_msb got %0b exp 0", branch_taken); end
   endtask

   task automatic test_stall();
      op = 6'h2B; harzard = 1'b1; #1;
      checks++; if (mem_w !== 1'b0 || is_immd !== 1'b1) begin errors++; $display("FAIL stall_sw got %0b/%0b exp 0/1", mem_w, is_immd); end
      op = 6'h00; funct = 6'h00; #1;
      checks++; if (wb_en !== 1'b0 || only_shamt !== 1'b1 || alu_op !== 4'd7) begin errors++; $display("FAIL stall_sll got %0b/%0b/%0d exp 0/1/7", wb_en, only_shamt, alu_op); end
      // A stalled halt must neither show nor latch.
      op = 6'h3F; #1;
      checks++; if (terminate !== 1'b0) begin errors++; $display("FAIL stall_halt got %0b exp 0", terminate); end
      @(posedge clk); #1;
      harzard = 1'b0; op = 6'h00; funct = 6'h20; #1;
      checks++; if (terminate !== 1'b0 || wb_en !== 1'b1) begin errors++; $display("FAIL stall_nolatch got %0b/%0b exp 0/1", terminate, wb_en); end
   endtask

   task automatic test_halt();
      @(negedge clk);
      op = 6'h3F; harzard = 1'b0; #1;
      checks++; if (terminate !== 1'b1 || wb_en !== 1'b0) begin errors++; $display("FAIL halt_dec got %0b/%0b exp 1/0", terminate, wb_en); end
      @(posedge clk); #1;
      op = 6'h00; funct = 6'h20; #1;
      checks++; if (terminate !== 1'b1 || wb_en !== 1'b0) begin errors++; $display("FAIL halt_sticky got %0b/%0b exp 1/0", terminate, wb_en); end
      op = 6'h23; #1;
      checks++; if (mem_r !== 1'b0 || is_immd !== 1'b1) begin errors++; $display("FAIL halt_lw got %0b/%0b exp 0/1", mem_r, is_immd); end
      @(posedge clk); #1;
      op = 6'h00;
      checks++; #1; if (terminate !== 1'b1) begin errors++; $display("FAIL halt_keep got %0b exp 1", terminate); end
      #2 rst = 1'b0; #1;
      checks++; if (terminate !== 1'b0) begin errors++; $display("FAIL halt_rst got %0b exp 0", terminate); end
      #1 rst = 1'b1; #1;
      checks++; if (terminate !== 1'b0 || wb_en !== 1'b1) begin errors++; $display("FAIL post_rst got %0b/%0b exp 0/1", terminate, wb_en); end
   endtask

   initial begin
      dm_sel = 1'b0; dm_in1 = '0; dm_in2 = '0;
      rm_sel = 1'b0; rm_in1 = '0; rm_in2 = '0;
      test_reset();
      test_add();
      test_sll();
      test_itype();
      test_lw_sw();
      test_branch();
      test_stall();
      test_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameters: none; data width is `WORD (32), the codebase-wide constant.
REQ-002 clk  input  1  system clock; only the halt flag is clocked, on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction[31:26].
REQ-005 funct  input  6  instruction[5:0].
REQ-006 harzard  input  1  stall request; turns the current instruction into a bubble.
REQ-007 reg_rs_d, reg_rt_d  input  32 each  register-file rs/rt values, used for branch compare.
REQ-008 is_immd  output  1  selects sign-extended immediate as ALU operand 2 and rt as destination.
REQ-009 only_shamt  output  1  selects zero-extended shamt as ALU operand 1.
REQ-010 mem_w, mem_r  output  1 each  data-memory write/read enable.
REQ-011 alu_op  output  4  ALU operation code.
REQ-012 wb_en  output  1  register write-back enable.
REQ-013 branch_taken, jump_taken  output  1 each  redirect PC by branch offset / to jump target.
REQ-014 terminate  output  1  halt indication.
REQ-015 Companion leaf modules in the same file: data_mux (sel 1, in1 32, in2 32, out 32) and reg_mux (sel 1, in1 5, in2 5, out 5).

Function
REQ-016 data_mux/reg_mux SHALL be purely combinational: out = in1 when sel=0, in2 when sel=1.
REQ-017 Decode SHALL be combinational, with zero cycle latency from op/funct/reg data to outputs.
REQ-018 alu_op encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLL=7, SRL=8, SRA=9.
REQ-019 op=0x00 (R-type): funct maps as follows, with wb_en=1 and is_immd=0.
- 0x20/0x21 -> ADD; 0x22/0x23 -> SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT.
- 0x00 SLL, 0x02 SRL, 0x03 SRA with only_shamt=1.
- 0x04 SLL, 0x06 SRL, 0x07 SRA (variable shifts) with only_shamt=0.
REQ-020 I-type ALU ops: is_immd=1, wb_en=1.
- 0x08/0x09 ADD; 0x0C AND; 0x0D OR; 0x0E XOR; 0x0A SLT.
REQ-021 lw (0x23): is_immd=1, mem_r=1, wb_en=1, alu_op=ADD.
REQ-022 sw (0x2B): is_immd=1, mem_w=1, wb_en=0, alu_op=ADD.
REQ-023 beq (0x04): branch_taken = (reg_rs_d == reg_rt_d); is_immd=0, wb_en=0, alu_op=SUB.
REQ-024 bne (0x05): branch_taken = (reg_rs_d != reg_rt_d); all 32-bit compare; otherwise as beq.
REQ-025 j (0x02): jump_taken=1, wb_en=0.
REQ-026 op=0x3F: terminate=1, all other enables 0.
REQ-027 Unlisted op or funct: all enables 0, is_immd=0, only_shamt=0, alu_op=ADD (NOP).
REQ-028 harzard=1: mem_w, mem_r, wb_en, branch_taken, jump_taken and the decoded terminate SHALL be 0; alu_op, is_immd and only_shamt still decode.
REQ-029 Halt flag: set on a rising clk edge when terminate is decoded with harzard=0; it is sticky.
REQ-030 Output terminate = decoded terminate OR halt flag.
REQ-031 While the halt flag is set, mem_w, mem_r, wb_en, branch_taken and jump_taken SHALL be 0.

Reset
REQ-032 rst=0 SHALL clear the halt flag immediately, independent of clk.
REQ-033 While rst=0: terminate, mem_w, mem_r, wb_en, branch_taken and jump_taken are 0; other outputs decode normally.
REQ-034 After rst deasserts, decoding resumes combinationally with no warm-up cycle.

Verification
REQ-035 Bench SHALL cover add: op=0, funct=0x20 -> alu_op=0, wb_en=1, is_immd=0, only_shamt=0, mem_r=mem_w=0.
REQ-036 Bench SHALL cover sll: op=0, funct=0x00 -> only_shamt=1, alu_op=7; data_mux sel=1, in2=5 -> out=5.
REQ-037 Bench SHALL cover lw/sw.
- op=0x23 -> is_immd=1, mem_r=1, wb_en=1.
- op=0x2B -> mem_w=1, wb_en=0.
- reg_mux sel=1, in2=0 -> out=0.
REQ-038 Bench SHALL cover branches:
- beq with rs_d=rt_d=0x1234 -> branch_taken=1.
- bne with the same data -> branch_taken=0.
- beq, rt_d=0x1235 -> branch_taken=0.
REQ-039 Bench SHALL cover stall: sw with harzard=1 -> mem_w=0, is_immd=1.
REQ-040 Bench SHALL cover halt: op=0x3F, one clk edge, then op=0x00/funct=0x20 -> terminate=1, wb_en=0; rst=0 -> terminate=0 immediately.
